// File: rtl/axum_xbar_pkg.sv
// rtl/axum_xbar_pkg.sv - shared FSM state type and index-width helpers for the axum crossbar
package axum_xbar_pkg;

   typedef enum logic {
      XbarIdle = 1'b0,
      XbarBusy = 1'b1
   } xbar_state_e;

   // Width of a host index; a single host still gets a one-bit index.
   function automatic int host_idx_w(input int nr_hosts);
      return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
   endfunction

   // Width of a device index; a single device still gets a one-bit index.
   function automatic int dev_idx_w(input int nr_devices);
      return (nr_devices > 1) ? $clog2(nr_devices) : 1;
   endfunction

endpackage

// File: rtl/axum_rr_arbiter.sv
// rtl/axum_rr_arbiter.sv - round-robin arbiter with combinational grant and registered pointer
module axum_rr_arbiter
   import axum_xbar_pkg::*;
#(
   parameter int N = 2,
   localparam int W = host_idx_w(N)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic [N-1:0] req_i,
   output logic         valid_o,
   output logic [W-1:0] idx_o,
   output logic [N-1:0] gnt_o
);

   logic [W-1:0] rr_ptr;
   logic         hi_hit;
   logic [W-1:0] hi_idx;
   logic         lo_hit;
   logic [W-1:0] lo_idx;

   // Winner is the lowest requester at or above rr_ptr, else the lowest requester overall (wrap).
   always_comb begin
      hi_hit = 1'b0;
      hi_idx = '0;
      lo_hit = 1'b0;
      lo_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[k]) begin
            lo_hit = 1'b1;
            lo_idx = W'(k);
            if (W'(k) >= rr_ptr) begin
               hi_hit = 1'b1;
               hi_idx = W'(k);
            end
         end
      end
      valid_o = lo_hit;
      idx_o   = hi_hit ? hi_idx : lo_idx;
      for (int k = 0; k < N; k++) begin
         gnt_o[k] = en_i && valid_o && (idx_o == W'(k));
      end
   end

   // Advance the pointer past the winner whenever a grant is actually issued.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr <= '0;
      end else if (en_i && valid_o) begin
         rr_ptr <= (idx_o == W'(N - 1)) ? '0 : idx_o + W'(1);
      end
   end

endmodule

// File: rtl/axum_xbar.sv
// rtl/axum_xbar.sv - single-outstanding host/device crossbar; AXUM_XBAR_TIMEOUT_EN enables the response timeout
module axum_xbar
   import axum_xbar_pkg::*;
#(
   parameter int NrHosts       = 2,
   parameter int NrDevices     = 4,
   parameter int DataWidth     = 32,
   parameter int AddressWidth  = 32,
   parameter int TimeoutCycles = 255
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      host_req_i             [NrHosts],
   output logic                      host_gnt_o             [NrHosts],
   input  logic [AddressWidth-1:0]   host_addr_i            [NrHosts],
   input  logic                      host_we_i              [NrHosts],
   input  logic [DataWidth/8-1:0]    host_be_i              [NrHosts],
   input  logic [DataWidth-1:0]      host_wdata_i           [NrHosts],
   output logic                      host_rvalid_o          [NrHosts],
   output logic [DataWidth-1:0]      host_rdata_o           [NrHosts],
   output logic                      host_err_o             [NrHosts],
   output logic                      device_req_o           [NrDevices],
   output logic [AddressWidth-1:0]   device_addr_o          [NrDevices],
   output logic                      device_we_o            [NrDevices],
   output logic [DataWidth/8-1:0]    device_be_o            [NrDevices],
   output logic [DataWidth-1:0]      device_wdata_o         [NrDevices],
   input  logic                      device_rvalid_i        [NrDevices],
   input  logic [DataWidth-1:0]      device_rdata_i         [NrDevices],
   input  logic                      device_err_i           [NrDevices],
   input  logic [AddressWidth-1:0]   cfg_device_addr_base_i [NrDevices],
   input  logic [AddressWidth-1:0]   cfg_device_addr_mask_i [NrDevices]
);

   localparam int HostIdxW = host_idx_w(NrHosts);
   localparam int DevIdxW  = dev_idx_w(NrDevices);

   xbar_state_e             state;
   logic [HostIdxW-1:0]     cur_host;
   logic [DevIdxW-1:0]      cur_dev;
   logic                    cur_unmapped;

   logic [NrHosts-1:0]      req_vec;
   logic [NrHosts-1:0]      gnt_vec;
   logic                    arb_en;
   logic                    arb_valid;
   logic [HostIdxW-1:0]     win_idx;
   logic                    grant;

   logic [AddressWidth-1:0] win_addr;
   logic                    win_we;
   logic [DataWidth/8-1:0]  win_be;
   logic [DataWidth-1:0]    win_wdata;
   logic                    dec_hit;
   logic [DevIdxW-1:0]      dec_idx;

   logic                    tgt_rvalid;
   logic [DataWidth-1:0]    tgt_rdata;
   logic                    tgt_err;
   logic                    resp_dev;
   logic                    resp_fire;
   logic [DataWidth-1:0]    resp_rdata;
   logic                    resp_err;
   logic                    timeout_hit;

   // Pack host requests for the arbiter; arbitration only runs while idle and out of reset.
   always_comb begin
      for (int h = 0; h < NrHosts; h++) begin
         req_vec[h] = host_req_i[h];
      end
      arb_en = (state == XbarIdle) && !rst_i;
   end

   axum_rr_arbiter #(
      .N (NrHosts)
   ) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (arb_en),
      .req_i   (req_vec),
      .valid_o (arb_valid),
      .idx_o   (win_idx),
      .gnt_o   (gnt_vec)
   );

   assign grant = arb_en && arb_valid;

   // Select the winning host's request fields.
   always_comb begin
      win_addr  = '0;
      win_we    = 1'b0;
      win_be    = '0;
      win_wdata = '0;
      for (int h = 0; h < NrHosts; h++) begin
         if (win_idx == HostIdxW'(h)) begin
            win_addr  = host_addr_i[h];
            win_we    = host_we_i[h];
            win_be    = host_be_i[h];
            win_wdata = host_wdata_i[h];
         end
      end
   end

   // Address decode; scanning downward lets the lowest matching device win.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int d = NrDevices - 1; d >= 0; d--) begin
         if ((win_addr & cfg_device_addr_mask_i[d]) == cfg_device_addr_base_i[d]) begin
            dec_hit = 1'b1;
            dec_idx = DevIdxW'(d);
         end
      end
   end

   // Forward the granted request to its device; idle device ports stay at zero.
   always_comb begin
      for (int d = 0; d < NrDevices; d++) begin
         device_req_o[d]   = grant && dec_hit && (dec_idx == DevIdxW'(d));
         device_addr_o[d]  = device_req_o[d] ? win_addr  : '0;
         device_we_o[d]    = device_req_o[d] ? win_we    : 1'b0;
         device_be_o[d]    = device_req_o[d] ? win_be    : '0;
         device_wdata_o[d] = device_req_o[d] ? win_wdata : '0;
      end
      for (int h = 0; h < NrHosts; h++) begin
         host_gnt_o[h] = gnt_vec[h];
      end
   end

   // Build the response: latched device only, otherwise an error for unmapped or timed-out targets.
   always_comb begin
      tgt_rvalid = 1'b0;
      tgt_rdata  = '0;
      tgt_err    = 1'b0;
      for (int d = 0; d < NrDevices; d++) begin
         if (cur_dev == DevIdxW'(d)) begin
            tgt_rvalid = device_rvalid_i[d];
            tgt_rdata  = device_rdata_i[d];
            tgt_err    = device_err_i[d];
         end
      end
      resp_dev   = (state == XbarBusy) && !cur_unmapped && tgt_rvalid;
      resp_fire  = (state == XbarBusy) && (cur_unmapped || tgt_rvalid || timeout_hit);
      resp_rdata = resp_dev ? tgt_rdata : '0;
      resp_err   = resp_dev ? tgt_err : 1'b1;
      for (int h = 0; h < NrHosts; h++) begin
         host_rvalid_o[h] = resp_fire && (cur_host == HostIdxW'(h));
         host_rdata_o[h]  = host_rvalid_o[h] ? resp_rdata : '0;
         host_err_o[h]    = host_rvalid_o[h] ? resp_err : 1'b0;
      end
   end

`ifdef AXUM_XBAR_TIMEOUT_EN
   localparam int TmoW = $clog2(TimeoutCycles + 1);
   logic [TmoW-1:0] tmo_cnt;

   // Count BUSY cycles; the count is zero on the first BUSY cycle and clears when the transaction ends.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_cnt <= '0;
      end else if ((state == XbarBusy) && !resp_fire) begin
         tmo_cnt <= tmo_cnt + TmoW'(1);
      end else begin
         tmo_cnt <= '0;
      end
   end

   assign timeout_hit = (state == XbarBusy) && !cur_unmapped && !tgt_rvalid &&
                        (tmo_cnt == TmoW'(TimeoutCycles - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // Two-state transaction FSM: latch host and target on grant, release on response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= XbarIdle;
         cur_host     <= '0;
         cur_dev      <= '0;
         cur_unmapped <= 1'b0;
      end else begin
         case (state)
            XbarIdle: begin
               if (grant) begin
                  cur_host     <= win_idx;
                  cur_dev      <= dec_idx;
                  cur_unmapped <= !dec_hit;
                  state        <= XbarBusy;
               end
            end
            XbarBusy: begin
               if (resp_fire) begin
                  state <= XbarIdle;
               end
            end
            default: state <= XbarIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_axum_xbar.sv
// tb/tb_axum_xbar.sv - self-checking bench for axum_xbar with device models and a response scoreboard
module tb_axum_xbar;

   localparam int NH = 2;
   localparam int ND = 4;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          host_req_i     [NH];
   logic          host_gnt_o     [NH];
   logic [AW-1:0] host_addr_i    [NH];
   logic          host_we_i      [NH];
   logic [3:0]    host_be_i      [NH];
   logic [DW-1:0] host_wdata_i   [NH];
   logic          host_rvalid_o  [NH];
   logic [DW-1:0] host_rdata_o   [NH];
   logic          host_err_o     [NH];
   logic          device_req_o   [ND];
   logic [AW-1:0] device_addr_o  [ND];
   logic          device_we_o    [ND];
   logic [3:0]    device_be_o    [ND];
   logic [DW-1:0] device_wdata_o [ND];
   logic          device_rvalid_i[ND];
   logic [DW-1:0] device_rdata_i [ND];
   logic          device_err_i   [ND];
   logic [AW-1:0] cfg_base       [ND];
   logic [AW-1:0] cfg_mask       [ND];

   axum_xbar #(
      .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
      .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
      .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
      .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
      .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
      .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i), .device_err_i(device_err_i),
      .cfg_device_addr_base_i(cfg_base), .cfg_device_addr_mask_i(cfg_mask)
   );

   always #5 clk = ~clk;

   // host, target device (-1 unmapped), request fields, expected rdata/err,
   // device latency (0 = never answers), expected response latency, grant cycle
   typedef struct {
      int            host;
      int            dev;
      logic [AW-1:0] addr;
      logic          we;
      logic [3:0]    be;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic          err;
      int            dlat;
      int            rlat;
      int            gcyc;
   } txn_t;

   txn_t          exp_q[$];
   txn_t          resp_q[$];
   int            gnt_h[$];
   int            gnt_c[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            n_gnt = 0;
   int            pend [ND];
   logic          kick [ND];
   logic [DW-1:0] ddata[ND];
   logic          derr [ND];
   logic          drv_fire;
   txn_t          me;
   txn_t          mr;
   logic [ND-1:0] act_req;
   logic [ND-1:0] exp_req;
   txn_t          vecs[8];
   txn_t          t;
   int            g0;
   int            gc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic any_out();
      logic a;
      a = 1'b0;
      for (int h = 0; h < NH; h++)
         a = a | host_gnt_o[h] | host_rvalid_o[h] | (|host_rdata_o[h]) | host_err_o[h];
      for (int d = 0; d < ND; d++)
         a = a | device_req_o[d] | (|device_addr_o[d]) | device_we_o[d] |
             (|device_be_o[d]) | (|device_wdata_o[d]);
      return a;
   endfunction

   task automatic wait_gnts(input int target, input int budget);
      int k;
      k = 0;
      while (n_gnt < target && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      if (n_gnt < target) check("grant_wait_expired", 64'(n_gnt), 64'(target));
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || resp_q.size() != 0) && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      if (exp_q.size() != 0 || resp_q.size() != 0) begin
         check("response_wait_expired", 64'(resp_q.size() + exp_q.size()), 64'd0);
         exp_q.delete();
         resp_q.delete();
      end
   endtask

   // Device models: answer pend cycles after their grant, or once when kicked; idle outputs carry junk.
   initial begin
      forever begin
         @(posedge clk); #1;
         for (int d = 0; d < ND; d++) begin
            drv_fire = kick[d];
            kick[d]  = 1'b0;
            if (pend[d] > 0) begin
               pend[d] = pend[d] - 1;
               if (pend[d] == 0) drv_fire = 1'b1;
            end
            device_rvalid_i[d] = drv_fire;
            device_rdata_i[d]  = drv_fire ? ddata[d] : (32'hBAD0_0000 | 32'(d));
            device_err_i[d]    = drv_fire ? derr[d] : 1'b1;
         end
      end
   end

   // Monitor: match grants against expected stimulus, then responses against the scoreboard.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         for (int h = 0; h < NH; h++) begin
            if (host_gnt_o[h]) begin
               n_gnt++;
               gnt_h.push_back(h);
               gnt_c.push_back(cyc);
               if (exp_q.size() == 0) begin
                  check("unexpected_grant", 64'(h + 1), 64'd0);
               end else begin
                  me = exp_q.pop_front();
                  check("grant_host", 64'(h), 64'(me.host));
                  for (int d = 0; d < ND; d++) act_req[d] = device_req_o[d];
                  exp_req = '0;
                  if (me.dev >= 0) exp_req[me.dev] = 1'b1;
                  check("device_req", 64'(act_req), 64'(exp_req));
                  if (me.dev >= 0) begin
                     check("device_addr", 64'(device_addr_o[me.dev]), 64'(me.addr));
                     check("device_we", 64'(device_we_o[me.dev]), 64'(me.we));
                     check("device_be", 64'(device_be_o[me.dev]), 64'(me.be));
                     check("device_wdata", 64'(device_wdata_o[me.dev]), 64'(me.wdata));
                     pend[me.dev] = me.dlat;
                  end
                  me.gcyc = cyc;
                  resp_q.push_back(me);
               end
            end
         end
         for (int h = 0; h < NH; h++) begin
            if (host_rvalid_o[h]) begin
               if (resp_q.size() == 0) begin
                  check("unexpected_rvalid", 64'(h + 1), 64'd0);
               end else begin
                  mr = resp_q.pop_front();
                  check("resp_host", 64'(h), 64'(mr.host));
                  check("resp_rdata", 64'(host_rdata_o[h]), 64'(mr.rdata));
                  check("resp_err", 64'(host_err_o[h]), 64'(mr.err));
                  check("resp_latency", 64'(cyc - mr.gcyc), 64'(mr.rlat));
               end
            end else begin
               check("idle_rdata_zero", 64'(host_rdata_o[h]), 64'd0);
               check("idle_err_zero", 64'(host_err_o[h]), 64'd0);
            end
         end
      end
   end

   function automatic txn_t mk(input int host, input int dev, input logic [AW-1:0] addr,
                               input logic we, input logic [3:0] be, input logic [DW-1:0] wdata,
                               input logic [DW-1:0] rdata, input logic err, input int dlat,
                               input int rlat);
      txn_t x;
      x.host = host;  x.dev = dev;     x.addr = addr;   x.we = we;     x.be = be;
      x.wdata = wdata; x.rdata = rdata; x.err = err;     x.dlat = dlat; x.rlat = rlat;
      x.gcyc = 0;
      return x;
   endfunction

   task automatic drive_host(input txn_t x);
      if (x.dev >= 0) begin
         ddata[x.dev] = x.rdata;
         derr[x.dev]  = x.err;
      end
      exp_q.push_back(x);
      host_addr_i[x.host]  = x.addr;
      host_we_i[x.host]    = x.we;
      host_be_i[x.host]    = x.be;
      host_wdata_i[x.host] = x.wdata;
      host_req_i[x.host]   = 1'b1;
   endtask

   initial begin
      vecs[0] = mk(0,  0, 32'h0010_0004, 1'b0, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0, 1, 1);
      vecs[1] = mk(1, -1, 32'h0090_0000, 1'b0, 4'hF, 32'h0,         32'h0,         1'b1, 0, 1);
      vecs[2] = mk(1,  1, 32'h0020_0010, 1'b1, 4'h3, 32'h1234_5678, 32'h0,         1'b0, 1, 1);
      vecs[3] = mk(0,  2, 32'h0020_F004, 1'b0, 4'hF, 32'h0,         32'h0000_A5A5, 1'b1, 3, 3);
      vecs[4] = mk(1,  3, 32'h0040_0000, 1'b1, 4'h8, 32'hFFFF_0000, 32'hCAFE_F00D, 1'b0, 2, 2);
      vecs[5] = mk(0,  0, 32'h0010_3FFC, 1'b0, 4'hF, 32'h0,         32'h0000_0001, 1'b0, 1, 1);
      vecs[6] = mk(0, -1, 32'h0010_4000, 1'b0, 4'hF, 32'h0,         32'h0,         1'b1, 0, 1);
      vecs[7] = mk(1, -1, 32'h0030_0000, 1'b1, 4'h1, 32'h55,        32'h0,         1'b1, 0, 1);

      cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFFF_C000;
      cfg_base[1] = 32'h0020_0000; cfg_mask[1] = 32'hFFFF_F000;
      cfg_base[2] = 32'h0020_0000; cfg_mask[2] = 32'hFFFF_0000;
      cfg_base[3] = 32'h0040_0000; cfg_mask[3] = 32'hFFFF_F000;
      for (int d = 0; d < ND; d++) begin
         pend[d] = 0; kick[d] = 1'b0; ddata[d] = '0; derr[d] = 1'b0;
         device_rvalid_i[d] = 1'b0; device_rdata_i[d] = '0; device_err_i[d] = 1'b0;
      end
      for (int h = 0; h < NH; h++) begin
         host_req_i[h] = 1'b1; host_addr_i[h] = 32'h0010_0000; host_we_i[h] = 1'b1;
         host_be_i[h] = 4'hF; host_wdata_i[h] = 32'hFFFF_FFFF;
      end

      // Reset with requests pending: every output must stay at zero.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1 check("reset_outputs_zero", 64'(any_out()), 64'd0);
      @(posedge clk); #2;
      for (int h = 0; h < NH; h++) host_req_i[h] = 1'b0;
      rst = 1'b0;

      // Single-host transactions from the vector table.
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #2;
         drive_host(vecs[i]);
         g0 = n_gnt;
         wait_gnts(g0 + 1, 20);
         @(posedge clk); #2;
         host_req_i[vecs[i].host] = 1'b0;
         wait_drain(40);
      end

      // Reset during BUSY aborts silently; afterwards contention alternates starting at host0.
      @(posedge clk); #2;
      drive_host(mk(0, 3, 32'h0040_0008, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 0, TO));
      g0 = n_gnt;
      wait_gnts(g0 + 1, 20);
      @(posedge clk); #2;
      host_req_i[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk); #1;
      check("reset_mid_busy_outputs_zero", 64'(any_out()), 64'd0);
      exp_q.delete();
      resp_q.delete();
      for (int d = 0; d < ND; d++) pend[d] = 0;
      gnt_h.delete();
      gnt_c.delete();
      @(posedge clk); #2;
      for (int k = 0; k < 4; k++) begin
         t = mk(k % 2, 0, (k % 2 == 0) ? 32'h0010_0000 : 32'h0010_0010, 1'b0, 4'hF, 32'h0,
                32'h0000_7000 + 32'(k), 1'b0, 1, 1);
         exp_q.push_back(t);
      end
      ddata[0] = 32'h0000_7000; derr[0] = 1'b0;
      host_addr_i[0] = 32'h0010_0000; host_addr_i[1] = 32'h0010_0010;
      host_we_i[0] = 1'b0; host_we_i[1] = 1'b0;
      host_be_i[0] = 4'hF; host_be_i[1] = 4'hF;
      host_wdata_i[0] = '0; host_wdata_i[1] = '0;
      host_req_i[0] = 1'b1; host_req_i[1] = 1'b1;
      g0 = n_gnt;
      rst = 1'b0;
      // Device 0 data steps per transaction so each scoreboard entry is distinct.
      for (int k = 0; k < 4; k++) begin
         wait_gnts(g0 + k + 1, 20);
         ddata[0] = 32'h0000_7000 + 32'(k);
      end
      @(posedge clk); #2;
      host_req_i[0] = 1'b0; host_req_i[1] = 1'b0;
      wait_drain(20);
      if (gnt_h.size() >= 4) begin
         for (int k = 0; k < 4; k++) check("contention_order", 64'(gnt_h[k]), 64'(k % 2));
         for (int k = 1; k < 4; k++) check("contention_spacing", 64'(gnt_c[k] - gnt_c[k-1]), 64'd2);
      end else begin
         check("contention_grant_count", 64'(gnt_h.size()), 64'd4);
      end

      // Slow device holds off a second host; a stray rvalid from another device is ignored.
      @(posedge clk); #2;
      drive_host(mk(1, 2, 32'h0020_F004, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0, 5, 5));
      g0 = n_gnt;
      wait_gnts(g0 + 1, 20);
      gc = gnt_c[$];
      @(posedge clk); #2;
      host_req_i[1] = 1'b0;
      drive_host(mk(0, 0, 32'h0010_0004, 1'b0, 4'hF, 32'h0, 32'h1111_2222, 1'b0, 1, 1));
      ddata[1] = 32'h3333_4444; derr[1] = 1'b0;
      kick[1] = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      check("ignore_other_device_rvalid", 64'({host_rvalid_o[1], host_rvalid_o[0]}), 64'd0);
      wait_gnts(g0 + 2, 20);
      check("slow_device_grant_gap", 64'(gnt_c[$] - gc), 64'd6);
      @(posedge clk); #2;
      host_req_i[0] = 1'b0;
      wait_drain(20);

`ifdef AXUM_XBAR_TIMEOUT_EN
      // Silent device times out on BUSY cycle TO; its late answer reaches no host.
      @(posedge clk); #2;
      drive_host(mk(0, 3, 32'h0040_0004, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 0, TO));
      g0 = n_gnt;
      wait_gnts(g0 + 1, 20);
      @(posedge clk); #2;
      host_req_i[0] = 1'b0;
      wait_drain(TO + 10);
      ddata[3] = 32'h5555_6666; derr[3] = 1'b0;
      kick[3] = 1'b1;
      @(negedge clk); #1;
      check("late_response_ignored", 64'({host_rvalid_o[1], host_rvalid_o[0]}), 64'd0);
      repeat (2) @(negedge clk);
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/axum_xbar.md
AXUM_XBAR -- requirements
Module: axum_xbar

Interface
REQ-001 SHALL have parameter NrHosts, default 2: number of bus hosts, 1..8.
REQ-002 SHALL have parameter NrDevices, default 4: number of bus devices, 1..16.
REQ-003 SHALL have parameter DataWidth, default 32: data bus width.
REQ-004 SHALL have parameter AddressWidth, default 32: address bus width.
REQ-005 SHALL have parameter TimeoutCycles, default 255: maximum response wait in cycles, used only under the timeout macro.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have host ports, each an unpacked array [NrHosts]:
- host_req_i, input, 1 bit
- host_gnt_o, output, 1 bit
- host_addr_i, input, AddressWidth
- host_we_i, input, 1 bit
- host_be_i, input, DataWidth/8
- host_wdata_i, input, DataWidth
- host_rvalid_o, output, 1 bit
- host_rdata_o, output, DataWidth
- host_err_o, output, 1 bit
REQ-009 SHALL have device ports, each an unpacked array [NrDevices]:
- device_req_o, output, 1 bit
- device_addr_o, output, AddressWidth
- device_we_o, output, 1 bit
- device_be_o, output, DataWidth/8
- device_wdata_o, output, DataWidth
- device_rvalid_i, input, 1 bit
- device_rdata_i, input, DataWidth
- device_err_i, input, 1 bit
REQ-010 SHALL have address map inputs cfg_device_addr_base_i and cfg_device_addr_mask_i, each [NrDevices] x AddressWidth.

Function
REQ-011 SHALL decode an address as device d when (addr & mask[d]) == base[d]; if several devices match, the lowest index wins; if none matches, the address is unmapped.
REQ-012 SHALL use a two-state FSM, IDLE and BUSY, allowing one outstanding transaction in total.
REQ-013 In IDLE, SHALL arbitrate round-robin among requesting hosts: the winner is the first requester at or after rr_ptr, with wrap-around.
REQ-014 In IDLE, the winner SHALL see host_gnt_o asserted in the same cycle (combinational).
- For a mapped address, device_req_o[d] and the winner's addr/we/be/wdata SHALL be forwarded to device d in that same cycle.
- For an unmapped address, no device_req_o SHALL assert.
REQ-015 On a grant, SHALL set rr_ptr <= (winner+1) mod NrHosts, latch the winning host index and the target (device index or unmapped), and move to BUSY.
REQ-016 In BUSY, SHALL assert no grants; host requests stay pending.
REQ-017 In BUSY with a mapped target: when device_rvalid_i[d] is high, SHALL drive host_rvalid_o[h] plus device_rdata_i[d] and device_err_i[d] in that same cycle, then return to IDLE.
REQ-018 In BUSY with an unmapped target: SHALL assert host_rvalid_o[h] with err=1 and rdata=0 in the first BUSY cycle, then return to IDLE.
REQ-019 SHALL ignore device_rvalid_i from any device other than the latched target.
REQ-020 SHALL drive host_rdata_o and host_err_o to 0 for any host whose host_rvalid_o is 0.
REQ-021 Minimum transaction time SHALL be 2 cycles: grant, then response; back-to-back grants SHALL be separated by at least one cycle.
REQ-022 With NrHosts=1, SHALL behave as a pure decoder: the grant follows the request whenever the FSM is in IDLE.

Reset
REQ-023 While rst_i is high, SHALL hold state=IDLE, rr_ptr=0 and the timeout counter at 0, with every output at 0.
REQ-024 Reset asserted mid-transaction SHALL abort it without issuing a response; after release, the FSM SHALL start in IDLE.

Configuration
REQ-025 With AXUM_XBAR_TIMEOUT_EN defined, SHALL count cycles spent in BUSY.
- If the count reaches TimeoutCycles without device_rvalid_i, SHALL assert host_rvalid_o[h] with err=1 and rdata=0, then return to IDLE.
- A device response arriving on exactly that cycle SHALL take priority over the timeout.
- A late device response arriving after the timeout SHALL be ignored.
REQ-026 Without AXUM_XBAR_TIMEOUT_EN, SHALL contain no counter and SHALL wait in BUSY indefinitely.

Structure
REQ-027 SHALL place the state enum (XbarIdle, XbarBusy) and the host/device index width helper functions in package axum_xbar_pkg.
REQ-028 SHALL implement the round-robin pointer and grant logic in sub-module axum_rr_arbiter, parameterised by N.

Verification
REQ-029 Single read: host0 reads 0x100004 (Ram base 0x100000, mask ~0x3FFF); device0 returns 0xDEADBEEF one cycle after grant -> host_rvalid_o[0]=1, rdata=0xDEADBEEF, err=0.
REQ-030 Contention: host0 and host1 both request continuously from reset -> grants alternate 0,1,0,1, each 2 cycles apart when devices respond in 1 cycle.
REQ-031 Unmapped: host1 reads 0x900000 -> no device_req_o asserts; host_rvalid_o[1]=1, err=1, rdata=0 one cycle after grant.
REQ-032 Slow device: device2 responds 5 cycles after grant while host0 also requests -> host0 receives no grant until the cycle after device2's rvalid.
REQ-033 Timeout (macro on, TimeoutCycles=8): device3 never responds -> err=1 on cycle 8 of BUSY; a later device3 rvalid produces no host rvalid.
REQ-034 Reset mid-BUSY: assert rst_i during the wait -> all outputs 0; after release, the first grant goes to host0.
